// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU / debug) arbiter and registered bus
// controller for a single variable-latency memory port.
// Optional build macro MEM_ARB_TIMEOUT_EN adds an ACC watchdog that forces
// completion with err=1 after TIMEOUT cycles without mem_ack.
//
// state | meaning
// IDLE  | arbitrate between cpu_req / dbg_req, latch the winning request
// ACC   | mem_cs high, mem_* stable, waiting for mem_ack
// DONE  | one-cycle completion pulse to the owner, requests ignored
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              MEM_R,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last;
    logic                r_locked;
    logic                r_byte;
    logic [1:0]          r_lane;
    logic                r_mem_cs;
    logic                r_mem_we;
    logic [3:0]          r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic                r_cpu_ack;
    logic                r_dbg_ack;
    logic                r_err;

    logic                w_dbg_elig;
    logic                w_grant_cpu;
    logic                w_grant_dbg;
    logic                w_finish;
    logic                w_tout;
    logic                w_tout_hit;
    logic [7:0]          w_lane_byte;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused;

    // Debug word accesses never use the byte offset.
    assign w_unused = &{1'b0, dbg_addr[1:0]};

    // While a swap is in progress the debug port is not eligible.
    assign w_dbg_elig = dbg_req && !r_locked;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] r_cnt;

    // Watchdog: cleared outside ACC, counts ACC cycles without mem_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_ACC) begin
            r_cnt <= '0;
        end else if (!mem_ack) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign err        = r_err;
`else
    assign w_tout_hit = 1'b0;
    assign err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_cpu = 1'b0;
        w_grant_dbg = 1'b0;
        w_finish    = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // CPU wins unless debug is eligible and CPU was served last.
                w_grant_cpu = cpu_req && (!w_dbg_elig || (r_last == OWN_DBG));
                w_grant_dbg = w_dbg_elig && !w_grant_cpu;
                if (w_grant_cpu || w_grant_dbg) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                // A real ack beats a coincident timeout.
                if (mem_ack) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_tout_hit) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read data steering: byte accesses return the addressed lane zero-extended.
    always_comb begin
        w_lane_byte = mem_rdata[7:0];
        case (r_lane)
            2'd0: w_lane_byte = mem_rdata[7:0];
            2'd1: w_lane_byte = mem_rdata[15:8];
            2'd2: w_lane_byte = mem_rdata[23:16];
            2'd3: w_lane_byte = mem_rdata[31:24];
            default: w_lane_byte = mem_rdata[7:0];
        endcase
        w_rdata = r_byte ? {{(DATA_W-8){1'b0}}, w_lane_byte} : mem_rdata;
        if (w_tout) begin
            w_rdata = '0;
        end
    end

    // Request latch, bus outputs, completion pulses and lock tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_CPU;
            r_last      <= OWN_DBG;
            r_locked    <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= 2'd0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_err     <= 1'b0;

            if (w_grant_cpu) begin
                r_owner     <= OWN_CPU;
                r_last      <= OWN_CPU;
                r_mem_cs    <= 1'b1;
                r_mem_we    <= cpu_we;
                r_mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= cpu_byte ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
                r_mem_wdata <= cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
                r_byte      <= cpu_byte;
                r_lane      <= cpu_addr[1:0];
            end else if (w_grant_dbg) begin
                r_owner     <= OWN_DBG;
                r_last      <= OWN_DBG;
                r_mem_cs    <= 1'b1;
                r_mem_we    <= dbg_we;
                r_mem_addr  <= {dbg_addr[ADDR_W-1:2], 2'b00};
                r_mem_be    <= 4'b1111;
                r_mem_wdata <= dbg_wdata;
                r_byte      <= 1'b0;
                r_lane      <= 2'd0;
            end

            if (w_finish || w_tout) begin
                r_mem_cs <= 1'b0;
                r_err    <= w_tout;
                if (r_owner == OWN_CPU) begin
                    r_cpu_ack   <= 1'b1;
                    r_cpu_rdata <= w_rdata;
                end else begin
                    r_dbg_ack   <= 1'b1;
                    r_dbg_rdata <= w_rdata;
                end
            end

            // A timed-out access never leaves the bus locked.
            if (r_state == S_DONE) begin
                r_locked <= (r_owner == OWN_CPU) && !r_err && cpu_lock;
            end
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign MEM_R     = r_cpu_ack;
    assign dbg_rdata = r_dbg_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: word/byte accesses, wait states,
// round-robin, swap lock, async reset during ACC and the ACC watchdog.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte, cpu_lock;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        MEM_R;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .MEM_R(MEM_R),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_lock = 0;
        cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        check("rst_cs", {31'b0, mem_cs}, 32'd0);
        check("rst_memr", {31'b0, MEM_R}, 32'd0);
        check("rst_dbgack", {31'b0, dbg_ack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_be", {28'b0, mem_be}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        do_reset();

        // CPU word load, zero-wait memory
        cpu_req = 1; cpu_addr = 32'h100;
        tick();                                  // edge 0
        check("wl_cs", {31'b0, mem_cs}, 32'd1);
        check("wl_be", {28'b0, mem_be}, 32'h0000000F);
        check("wl_addr", mem_addr, 32'h100);
        check("wl_we", {31'b0, mem_we}, 32'd0);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();                                  // edge 1
        check("wl_memr", {31'b0, MEM_R}, 32'd1);
        check("wl_rdata", cpu_rdata, 32'hDEADBEEF);
        check("wl_cs_off", {31'b0, mem_cs}, 32'd0);
        check("wl_err", {31'b0, err}, 32'd0);
        cpu_req = 0; mem_ack = 0;
        tick();                                  // edge 2
        check("wl_memr_off", {31'b0, MEM_R}, 32'd0);

        // CPU byte store to 0x203, two wait states
        cpu_req = 1; cpu_we = 1; cpu_byte = 1; cpu_addr = 32'h203; cpu_wdata = 32'h1234565A;
        tick();
        check("bs_addr", mem_addr, 32'h200);
        check("bs_be", {28'b0, mem_be}, 32'h00000008);
        check("bs_wdata", mem_wdata, 32'h5A5A5A5A);
        check("bs_we", {31'b0, mem_we}, 32'd1);
        tick();
        check("bs_wait1_cs", {31'b0, mem_cs}, 32'd1);
        check("bs_wait1_memr", {31'b0, MEM_R}, 32'd0);
        tick();
        check("bs_wait2_cs", {31'b0, mem_cs}, 32'd1);
        check("bs_wait2_addr", mem_addr, 32'h200);
        mem_ack = 1;
        tick();
        check("bs_memr", {31'b0, MEM_R}, 32'd1);
        cpu_req = 0; cpu_we = 0; cpu_byte = 0; mem_ack = 0;
        tick();

        // CPU byte load from 0x102: lane 2 zero-extended
        cpu_req = 1; cpu_byte = 1; cpu_addr = 32'h102;
        tick();
        check("bl_be", {28'b0, mem_be}, 32'h00000004);
        check("bl_addr", mem_addr, 32'h100);
        mem_ack = 1; mem_rdata = 32'hAABBCCDD;
        tick();
        check("bl_memr", {31'b0, MEM_R}, 32'd1);
        check("bl_rdata", cpu_rdata, 32'h000000BB);
        cpu_req = 0; cpu_byte = 0; mem_ack = 0;
        tick();

        // Round-robin from reset, both requests held, zero-wait memory
        do_reset();
        cpu_req = 1; cpu_addr = 32'h10;
        dbg_req = 1; dbg_addr = 32'h20;
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_cs_%0d", i), {31'b0, mem_cs}, {31'b0, (i % 3) == 0});
            check($sformatf("rr_memr_%0d", i), {31'b0, MEM_R}, {31'b0, (i == 1) || (i == 7)});
            check($sformatf("rr_dbgack_%0d", i), {31'b0, dbg_ack}, {31'b0, i == 4});
            if (i == 0 || i == 6) check($sformatf("rr_addr_%0d", i), mem_addr, 32'h10);
            if (i == 3) check("rr_addr_dbg", mem_addr, 32'h20);
            if (i == 4) check("rr_dbg_rdata", dbg_rdata, 32'h0BADF00D);
        end
        cpu_req = 0; dbg_req = 0; mem_ack = 0;
        tick(); tick();

        // Swap: locked read then write, debug waits until lock released
        do_reset();
        cpu_req = 1; cpu_addr = 32'h40; cpu_lock = 1;
        dbg_req = 1; dbg_addr = 32'h80;
        mem_ack = 1; mem_rdata = 32'h11223344;
        tick();                                  // read granted
        check("sw_rd_addr", mem_addr, 32'h40);
        check("sw_rd_we", {31'b0, mem_we}, 32'd0);
        tick();                                  // read DONE, lock sampled next edge
        check("sw_rd_memr", {31'b0, MEM_R}, 32'd1);
        check("sw_rd_data", cpu_rdata, 32'h11223344);
        cpu_we = 1; cpu_wdata = 32'hCAFE0000;
        tick();                                  // IDLE, locked
        cpu_lock = 0;
        tick();                                  // write granted over pending debug
        check("sw_wr_cs", {31'b0, mem_cs}, 32'd1);
        check("sw_wr_addr", mem_addr, 32'h40);
        check("sw_wr_we", {31'b0, mem_we}, 32'd1);
        check("sw_wr_wdata", mem_wdata, 32'hCAFE0000);
        tick();
        check("sw_wr_memr", {31'b0, MEM_R}, 32'd1);
        check("sw_wr_dbgack", {31'b0, dbg_ack}, 32'd0);
        cpu_req = 0; cpu_we = 0;
        tick();                                  // IDLE, lock released
        tick();                                  // debug granted
        check("sw_dbg_cs", {31'b0, mem_cs}, 32'd1);
        check("sw_dbg_addr", mem_addr, 32'h80);
        tick();
        check("sw_dbg_ack", {31'b0, dbg_ack}, 32'd1);
        dbg_req = 0; mem_ack = 0;
        tick();

        // Async reset in the second ACC cycle
        cpu_req = 1; cpu_addr = 32'h300;
        tick();
        tick();                                  // now in second ACC cycle
        check("ra_cs_before", {31'b0, mem_cs}, 32'd1);
        rst = 1;
        #1;
        check("ra_cs", {31'b0, mem_cs}, 32'd0);
        check("ra_memr", {31'b0, MEM_R}, 32'd0);
        check("ra_err", {31'b0, err}, 32'd0);
        mem_ack = 1;
        tick();
        check("ra_no_pulse", {31'b0, MEM_R}, 32'd0);
        rst = 0; mem_ack = 0; mem_rdata = 32'h00C0FFEE;
        tick();
        check("ra_new_cs", {31'b0, mem_cs}, 32'd1);
        check("ra_new_addr", mem_addr, 32'h300);
        mem_ack = 1;
        tick();
        check("ra_new_memr", {31'b0, MEM_R}, 32'd1);
        check("ra_new_rdata", cpu_rdata, 32'h00C0FFEE);
        cpu_req = 0; mem_ack = 0;
        tick();

        // Memory never acks
        mem_rdata = 32'h12345678;
        cpu_req = 1; cpu_addr = 32'h500;
        tick();                                  // edge 0, ACC cycle 1 begins
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            tick();
            check($sformatf("to_wait_%0d", i), {31'b0, mem_cs}, 32'd1);
        end
        tick();                                  // end of 15th ACC cycle
        check("to_memr", {31'b0, MEM_R}, 32'd1);
        check("to_err", {31'b0, err}, 32'd1);
        check("to_rdata", cpu_rdata, 32'd0);
        check("to_cs", {31'b0, mem_cs}, 32'd0);
        cpu_req = 0;
        tick();
        check("to_err_off", {31'b0, err}, 32'd0);
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            check($sformatf("hang_cs_%0d", i), {31'b0, mem_cs}, 32'd1);
            if (MEM_R !== 1'b0 || err !== 1'b0) check("hang_no_done", {30'b0, MEM_R, err}, 32'd0);
        end
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
